seg_display_driver: RTL and testbench
=====================================

# seg_display_driver

Eight-digit seven-segment display driver that sits downstream of the ecall I/O handler and turns its 32-bit display word into multiplexed anode/cathode drive for the board's 8-digit common-anode display. The block converts each new word into digit codes, with optional unsigned-decimal conversion. It applies leading-zero blanking and an overflow indication, and scans the digits on the slow clock domain. Displayed digits change only when a conversion completes, so a digit never shows a mix of old and new values.

## Interface
Parameters:
- SCAN_DIV, 16: clk_slow cycles per digit slot (≥2).

Ports:
- clk_slow  in  1  display/scan clock.
- rst  in  1  reset; synchronous, active-low.
- seg_data  in  32  value to display, from the I/O handler's display register.
- dec_sel  in  1  1 = unsigned decimal, 0 = hex. Ignored without DEC_DISPLAY_EN.
- seg_an  out  8  digit anodes, active-low; bit i = digit i, where digit 0 is the rightmost.
- seg_cat  out  8  cathodes, active-low; [0]=a … [6]=g, [7]=dp.
- busy  out  1  high while a conversion is in flight.

## Operation
- Source latch: src_data and src_sel hold the value and mode of the last conversion started. Reset value is 0 and 0.
- FSM states:
  - IDLE: if {seg_data, dec_sel} differs from {src_data, src_sel}, latch both into the source latch. Go to SHIFT if decimal is selected, otherwise to COMMIT.
  - SHIFT: double-dabble over 32 iterations, one bit per cycle, MSB first. Before each shift, add 3 to every 4-bit BCD digit ≥5. The result is a 40-bit, 10-digit BCD value. After iteration 32, go to COMMIT.
  - COMMIT: load the display registers from the result, then go to IDLE.
  - busy is high whenever the FSM is not in IDLE.
- Input changes during SHIFT or COMMIT are not sampled. The first IDLE cycle afterwards compares against the latch again and restarts if the input still differs, so the final value always wins.
- Display registers:
  - digit[7:0][3:0]: in hex mode, nibble i of src_data; in decimal mode, BCD digit i.
  - blank[7:0]: leading-zero blanking. Digit i is blanked if it and every higher digit are zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
  - ovf: set in decimal mode when BCD digit 8 or 9 is nonzero (value > 99,999,999).
- Cathode encoding, active-low, dp always off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8.
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - dash=BF, blank=FF.
- When ovf is set, all 8 digits show a dash and blank[] is ignored.
- Scan:
  - A prescaler counts 0..SCAN_DIV-1. On wrap, the digit index counts 0..7 and then wraps to 0.
  - When the prescaler is 0 (ghost guard), seg_an is FF and seg_cat is FF.
  - Otherwise seg_an = ~(1<<idx). seg_cat = dash if ovf, else FF if blank[idx], else the code for digit[idx].
- Outputs are registered.

## Timing
- Reset values:
  - seg_an = FF, seg_cat = FF, busy = 0, FSM = IDLE.
  - Prescaler = 0, idx = 0.
  - digit = 0, blank = FE, ovf = 0.
- Reset during SHIFT aborts the conversion. The display returns to "0" and the source latch returns to 0, so a nonzero seg_data is reconverted after reset is released.
- Hex latency: change sampled at edge E0 (IDLE), COMMIT at E1. New registers are used from E2, with busy high for exactly 1 cycle.
- Decimal latency: E0 latch, E1..E32 SHIFT, COMMIT at E33. busy is high for 33 cycles.
- Changing only dec_sel triggers a reconversion of the same value.
- Full scan frame = 8·SCAN_DIV cycles. Each digit is lit for SCAN_DIV-1 cycles per frame.

## Configuration
- DEC_DISPLAY_EN defined:
  - Decimal mode, the SHIFT state, the BCD datapath and ovf are compiled in.
- DEC_DISPLAY_EN undefined:
  - dec_sel is ignored and treated as 0; hex only.
  - The SHIFT state and BCD logic are absent, and ovf is tied to 0.
  - Every conversion takes 1 busy cycle.

## Test plan
- Reset, then run one frame with seg_data=0 → digit 0 shows C0 and digits 1–7 show FF. seg_an is FF on every prescaler-0 cycle, and busy stays 0.
- Hex mode, seg_data=0x00A1F003 → busy for 1 cycle. Digits 0..5 show B0, C0, C0, 8E, F9, 88; digits 6–7 show FF.
- Decimal mode, seg_data=12345678 → busy for exactly 33 cycles, then digits 7..0 show F9, A4, B0, 99, 92, 82, F8, 80.
- Decimal mode, seg_data=100000000 → ovf set and all 8 digits show BF. Then seg_data=99999999 → all digits show 90.
- Change seg_data from 5 to 7 at SHIFT iteration 10 → 5 is committed first, then a second 33-cycle conversion runs and the display shows 7. Assert rst mid-SHIFT → reset values appear on the next edge.
- Build without DEC_DISPLAY_EN, dec_sel=1, seg_data=16 → hex "10" (F9, C0) with 1-cycle busy.

Source files
------------

// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed seven-segment driver: hex or unsigned-decimal conversion, blanking, overflow dashes.
// Decimal conversion (SHIFT state, BCD datapath, ovf) is present only when DEC_DISPLAY_EN is defined.
module seg_display_driver #(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk_slow,
  input  logic        rst,
  input  logic [31:0] seg_data,
  input  logic        dec_sel,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat,
  output logic        busy
);

  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef DEC_DISPLAY_EN
    SHIFT  = 2'd1,
`endif
    COMMIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    src_data_q, src_data_d;
  logic           src_sel_q, src_sel_d;
  logic [31:0]    digit_q, digit_d;
  logic [7:0]     blank_q, blank_d;
  logic           ovf_q, ovf_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     seg_an_q, seg_an_d;
  logic [7:0]     seg_cat_q, seg_cat_d;
  logic           busy_q;
  logic           dec_eff;
  logic [31:0]    digit_new;
  logic [7:0]     blank_new;
  logic           ovf_new;

`ifdef DEC_DISPLAY_EN
  logic [39:0] bcd_q, bcd_d;
  logic [31:0] sh_q, sh_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [39:0] bcd_adj;
  logic        unused_bcd_msb;

  assign dec_eff = dec_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_dabble
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                              : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // The adjusted top bit is shifted out; it is always zero for a 32-bit input.
  assign unused_bcd_msb = bcd_adj[39];
  assign digit_new = src_sel_q ? bcd_q[31:0] : src_data_q;
  assign ovf_new   = src_sel_q & (|bcd_q[39:32]);
`else
  logic unused_dec_sel;

  assign unused_dec_sel = dec_sel;
  assign dec_eff   = 1'b0;
  assign digit_new = src_data_q;
  assign ovf_new   = 1'b0;
`endif

  // A digit is blanked when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    logic zero_run;
    blank_new = '0;
    zero_run  = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_run     = zero_run & (digit_new[i*4 +: 4] == 4'd0);
      blank_new[i] = zero_run;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_data_d = src_data_q;
    src_sel_d  = src_sel_q;
    digit_d    = digit_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;
`ifdef DEC_DISPLAY_EN
    bcd_d = bcd_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if ({seg_data, dec_eff} != {src_data_q, src_sel_q}) begin
          src_data_d = seg_data;
          src_sel_d  = dec_eff;
`ifdef DEC_DISPLAY_EN
          if (dec_eff) begin
            state_d = SHIFT;
            bcd_d   = '0;
            sh_d    = seg_data;
            cnt_d   = '0;
          end else begin
            state_d = COMMIT;
          end
`else
          state_d = COMMIT;
`endif
        end
      end
`ifdef DEC_DISPLAY_EN
      SHIFT: begin
        {bcd_d, sh_d} = {bcd_adj[38:0], sh_q, 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = COMMIT;
      end
`endif
      COMMIT: begin
        digit_d = digit_new;
        blank_d = blank_new;
        ovf_d   = ovf_new;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  function automatic logic [7:0] seg_code(input logic [3:0] v);
    logic [7:0] c;
    case (v)
      4'h0: c = 8'hC0;  4'h1: c = 8'hF9;  4'h2: c = 8'hA4;  4'h3: c = 8'hB0;
      4'h4: c = 8'h99;  4'h5: c = 8'h92;  4'h6: c = 8'h82;  4'h7: c = 8'hF8;
      4'h8: c = 8'h80;  4'h9: c = 8'h90;  4'hA: c = 8'h88;  4'hB: c = 8'h83;
      4'hC: c = 8'hC6;  4'hD: c = 8'hA1;  4'hE: c = 8'h86;  default: c = 8'h8E;
    endcase
    return c;
  endfunction

  // Output registers are driven from the next scan position so they line up with presc_q/idx_q.
  always_comb begin
    logic wrap;
    wrap      = (presc_q == PW'(SCAN_DIV - 1));
    presc_d   = wrap ? '0 : presc_q + PW'(1);
    idx_d     = wrap ? idx_q + 3'd1 : idx_q;
    seg_an_d  = 8'hFF;
    seg_cat_d = 8'hFF;
    if (presc_d != '0) begin
      seg_an_d = ~(8'd1 << idx_d);
      if (ovf_q)               seg_cat_d = 8'hBF;
      else if (!blank_q[idx_d]) seg_cat_d = seg_code(digit_q[{idx_d, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      state_q    <= IDLE;
      src_data_q <= '0;
      src_sel_q  <= 1'b0;
      digit_q    <= '0;
      blank_q    <= 8'hFE;
      ovf_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_an_q   <= 8'hFF;
      seg_cat_q  <= 8'hFF;
      busy_q     <= 1'b0;
`ifdef DEC_DISPLAY_EN
      bcd_q      <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_data_q <= src_data_d;
      src_sel_q  <= src_sel_d;
      digit_q    <= digit_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_an_q   <= seg_an_d;
      seg_cat_q  <= seg_cat_d;
      busy_q     <= (state_d != IDLE);
`ifdef DEC_DISPLAY_EN
      bcd_q      <= bcd_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign seg_an  = seg_an_q;
  assign seg_cat = seg_cat_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: busy length per conversion and one scanned frame per display value.
module tb_seg_display_driver;
  localparam int SCAN_DIV = 4;

  logic        clk_slow = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] seg_data = 32'd0;
  logic        dec_sel = 1'b0;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;
  logic        busy;

  int n_checks = 0;
  int n_pass = 0;

  seg_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_slow(clk_slow),
    .rst(rst),
    .seg_data(seg_data),
    .dec_sel(dec_sel),
    .seg_an(seg_an),
    .seg_cat(seg_cat),
    .busy(busy)
  );

  always #5 clk_slow = ~clk_slow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Waits (bounded) for busy to rise, then measures how many cycles it stays high.
  task automatic busy_run(input string tag, input int exp_len);
    int w;
    int len;
    w = 0;
    len = 0;
    while (!busy && w < 20) begin
      @(negedge clk_slow);
      w++;
    end
    while (busy && len < 200) begin
      len++;
      @(negedge clk_slow);
    end
    chk(tag, len, exp_len);
    $display("tx %s: data=%0h dec=%0b busy_len=%0d", tag, seg_data, dec_sel, len);
  endtask

  // Captures one full scan frame; exp packs the cathode codes as {d7,...,d0}.
  task automatic frame(input string tag, input logic [63:0] exp);
    int ghost;
    int ghost_bad;
    int bad_an;
    int busy_seen;
    int lit_bad;
    int incons;
    int lit [8];
    logic [7:0] got [8];
    logic [7:0] pat;
    logic found;
    ghost = 0; ghost_bad = 0; bad_an = 0; busy_seen = 0; lit_bad = 0; incons = 0;
    for (int i = 0; i < 8; i++) begin
      lit[i] = 0;
      got[i] = 8'h00;
    end
    @(negedge clk_slow);
    repeat (8 * SCAN_DIV) begin
      @(negedge clk_slow);
      if (busy) busy_seen++;
      if (seg_an == 8'hFF) begin
        ghost++;
        if (seg_cat != 8'hFF) ghost_bad++;
      end else begin
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          pat = ~(8'd1 << i);
          if (seg_an == pat) begin
            if (lit[i] > 0 && got[i] != seg_cat) incons++;
            lit[i]++;
            got[i] = seg_cat;
            found = 1'b1;
          end
        end
        if (!found) bad_an++;
      end
    end
    for (int i = 0; i < 8; i++) if (lit[i] != SCAN_DIV - 1) lit_bad++;
    chk({tag, "_ghost_cnt"}, ghost, 8);
    chk({tag, "_ghost_cat"}, ghost_bad, 0);
    chk({tag, "_an_pattern"}, bad_an, 0);
    chk({tag, "_lit_cycles"}, lit_bad, 0);
    chk({tag, "_cat_stable"}, incons, 0);
    chk({tag, "_busy_idle"}, busy_seen, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_d%0d", tag, i), got[i], exp[i*8 +: 8]);
    $display("tx frame %s: d7..d0 = %h %h %h %h %h %h %h %h", tag,
             got[7], got[6], got[5], got[4], got[3], got[2], got[1], got[0]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk_slow);
    chk("rst_an", seg_an, 8'hFF);
    chk("rst_cat", seg_cat, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;

    frame("zero", 64'hFFFF_FFFF_FFFF_FFC0);

    seg_data = 32'h00A1_F003;
    busy_run("hex_busy", 1);
    frame("hex", 64'hFFFF_88F9_8EC0_C0B0);

`ifdef DEC_DISPLAY_EN
    dec_sel = 1'b1;
    seg_data = 32'd12345678;
    busy_run("dec_busy", 33);
    frame("dec", 64'hF9A4_B099_9282_F880);

    seg_data = 32'd100000000;
    busy_run("ovf_busy", 33);
    frame("ovf", 64'hBFBF_BFBF_BFBF_BFBF);

    seg_data = 32'd99999999;
    busy_run("max_busy", 33);
    frame("max", 64'h9090_9090_9090_9090);

    dec_sel = 1'b0;
    busy_run("sel_busy", 1);
    frame("sel_hex", 64'hFF92_8E92_86C0_8E8E);

    begin
      logic trace [120];
      int p;
      int r1;
      int g;
      int r2;
      dec_sel = 1'b1;
      seg_data = 32'd5;
      for (int i = 0; i < 120; i++) begin
        if (i == 10) seg_data = 32'd7;
        @(negedge clk_slow);
        trace[i] = busy;
      end
      p = 0; r1 = 0; g = 0; r2 = 0;
      while (p < 120 && trace[p]) begin p++; r1++; end
      while (p < 120 && !trace[p]) begin p++; g++; end
      while (p < 120 && trace[p]) begin p++; r2++; end
      chk("mid_run1", r1, 33);
      chk("mid_gap", g, 1);
      chk("mid_run2", r2, 33);
      $display("tx midchange 5->7: run1=%0d gap=%0d run2=%0d", r1, g, r2);
    end
    frame("mid7", 64'hFFFF_FFFF_FFFF_FFF8);

    seg_data = 32'd12345678;
    repeat (6) @(negedge clk_slow);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk_slow);
    chk("midrst_an", seg_an, 8'hFF);
    chk("midrst_cat", seg_cat, 8'hFF);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b1;
    busy_run("reconv_busy", 33);
    frame("reconv", 64'hF9A4_B099_9282_F880);
`else
    dec_sel = 1'b1;
    seg_data = 32'd16;
    busy_run("nodec_busy", 1);
    frame("nodec", 64'hFFFF_FFFF_FFFF_F9C0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
